// File: rtl/unified_mem_pkg.sv
// Shared encodings for the backing memory and the cache controller.
// State and op codes are reused by the controller.
package unified_mem_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int LINE_W_DEF = 64;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/unified_mem_if.sv
// Line-granular re/we/rdy handshake between cache controller and memory.
interface unified_mem_if
    import unified_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) ();

    logic              re;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
    logic              rdy;

    modport master (
        output re, we, addr, wdata,
        input  rdata, rdy
    );

    modport slave (
        input  re, we, addr, wdata,
        output rdata, rdy
    );

endinterface

// File: rtl/unified_mem_array.sv
// Single-port synchronous line RAM; dout only updates on reads.
module unified_mem_array #(
    parameter int ADDR_W = 14,
    parameter int LINE_W = 64
) (
    input  logic              clk,
    input  logic              en,
    input  logic              wen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LINE_W-1:0] din,
    output logic [LINE_W-1:0] dout
);

    logic [LINE_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (en) begin
            if (wen) mem[addr] <= din;
            else     dout      <= mem[addr];
        end
    end

endmodule

// File: rtl/unified_mem.sv
// Fixed-latency backing memory: IDLE/BUSY/DONE FSM around a sync RAM.
// RAM access happens on the edge entering DONE; rdy is decoded from state.
module unified_mem
    import unified_mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int LINE_W  = LINE_W_DEF,
    parameter int LATENCY = 4
) (
    input  logic         clk,
    input  logic         rst,
    unified_mem_if.slave bus
);

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t            state, state_n;
    logic [3:0]        cnt, cnt_n;
    op_t               op_q, op_cur;
    logic [ADDR_W-1:0] addr_q, ram_addr;
    logic [LINE_W-1:0] wdata_q, ram_din;
    logic [LINE_W-1:0] rdata_q, dout;
    logic              accept, commit;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.re | bus.we) begin
                    accept  = 1'b1;
                    cnt_n   = LAT_M1;
                    state_n = (LATENCY == 1) ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt == 4'd1 || cnt == 4'd0) state_n = S_DONE;
                else                            cnt_n   = cnt - 4'd1;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // With LATENCY=1 the commit edge is also the accept edge, so the
    // RAM must see the live request rather than the latches.
    always_comb begin
        op_cur   = op_q;
        ram_addr = addr_q;
        ram_din  = wdata_q;
        if (state == S_IDLE) begin
            op_cur   = bus.we ? OP_WRITE : OP_READ;
            ram_addr = bus.addr;
            ram_din  = bus.wdata;
        end
    end

    assign commit = (state_n == S_DONE) && (state != S_DONE);

    unified_mem_array #(
        .ADDR_W(ADDR_W),
        .LINE_W(LINE_W)
    ) u_array (
        .clk  (clk),
        .en   (commit && !rst),
        .wen  (op_cur == OP_WRITE),
        .addr (ram_addr),
        .din  (ram_din),
        .dout (dout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                op_q    <= bus.we ? OP_WRITE : OP_READ;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
            end
            if (state == S_DONE && op_q == OP_READ) rdata_q <= dout;
        end
    end

    assign bus.rdy   = (state == S_DONE);
    assign bus.rdata = (state == S_DONE && op_q == OP_READ) ? dout : rdata_q;

endmodule

// File: tb/tb_unified_mem.sv
// Directed bench for unified_mem: latency, evict/fill, collisions, resets.
module tb_unified_mem;
    import unified_mem_pkg::*;

    localparam int AW  = 14;
    localparam int LW  = 64;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    unified_mem_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

    unified_mem #(
        .ADDR_W (AW),
        .LINE_W (LW),
        .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic access(input logic w, input logic r,
                          input logic [AW-1:0] a, input logic [LW-1:0] d,
                          output int edges, output logic [LW-1:0] q);
        bus.we    = w;
        bus.re    = r;
        bus.addr  = a;
        bus.wdata = d;
        edges     = -1;
        q         = '0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.rdy) begin
                edges = i;
                q     = bus.rdata;
                break;
            end
        end
        bus.re = 1'b0;
        bus.we = 1'b0;
    endtask

    int            e;
    int            pulses;
    int            first;
    logic [LW-1:0] q;

    initial begin
        rst       = 1'b1;
        bus.re    = 1'b1;
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_rdy", 64'(bus.rdy), 64'd0);
            chk("rst_rdata", bus.rdata, 64'd0);
        end
        rst    = 1'b0;
        bus.re = 1'b0;
        tick();
        chk("rst_state", 64'(dut.state), 64'(S_IDLE));

        access(1'b1, 1'b0, 14'h0010, 64'h0123_4567_89AB_CDEF, e, q);
        chk("pre10_lat", 64'(e), 64'd4);
        tick();

        access(1'b0, 1'b1, 14'h0010, 64'h0, e, q);
        chk("rd_lat", 64'(e), 64'd4);
        chk("rd_data", q, 64'h0123_4567_89AB_CDEF);
        tick();
        chk("rd_rdy_low", 64'(bus.rdy), 64'd0);
        chk("rd_hold", bus.rdata, 64'h0123_4567_89AB_CDEF);

        access(1'b1, 1'b0, 14'h0020, 64'hDEAD_BEEF_CAFE_F00D, e, q);
        chk("ev_lat", 64'(e), 64'd4);
        chk("ev_rdata_kept", q, 64'h0123_4567_89AB_CDEF);
        access(1'b0, 1'b1, 14'h0020, 64'h0, e, q);
        chk("fill_lat", 64'(e), 64'd5);
        chk("fill_data", q, 64'hDEAD_BEEF_CAFE_F00D);
        tick();

        access(1'b1, 1'b1, 14'h0030, 64'h1, e, q);
        chk("both_lat", 64'(e), 64'd4);
        chk("both_rdata_kept", q, 64'hDEAD_BEEF_CAFE_F00D);
        tick();
        access(1'b0, 1'b1, 14'h0030, 64'h0, e, q);
        chk("both_rd", q, 64'h1);
        tick();

        bus.re   = 1'b1;
        bus.addr = 14'h0010;
        tick();
        bus.re   = 1'b0;
        bus.addr = 14'h0020;
        pulses   = 0;
        first    = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (bus.rdy) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        chk("drop_pulses", 64'(pulses), 64'd1);
        chk("drop_first", 64'(first), 64'd3);
        chk("drop_data", bus.rdata, 64'h0123_4567_89AB_CDEF);

        access(1'b1, 1'b0, 14'h0040, 64'h5, e, q);
        chk("pre40_lat", 64'(e), 64'd4);
        tick();
        bus.we    = 1'b1;
        bus.addr  = 14'h0040;
        bus.wdata = 64'hBAD;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        bus.we = 1'b0;
        chk("rstw_state", 64'(dut.state), 64'(S_IDLE));
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.rdy) pulses++;
        end
        chk("rstw_no_rdy", 64'(pulses), 64'd0);
        access(1'b0, 1'b1, 14'h0040, 64'h0, e, q);
        chk("rstw_rd", q, 64'h5);
        tick();

        access(1'b1, 1'b0, 14'h0050, 64'h7, e, q);
        chk("pre50_lat", 64'(e), 64'd4);
        tick();
        bus.we    = 1'b1;
        bus.addr  = 14'h0050;
        bus.wdata = 64'hFF;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        bus.we = 1'b0;
        chk("rstc_rdy", 64'(bus.rdy), 64'd0);
        tick();
        access(1'b0, 1'b1, 14'h0050, 64'h0, e, q);
        chk("rstc_rd_lat", 64'(e), 64'd4);
        chk("rstc_rd", q, 64'h7);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
